// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared key-path types, timing constants and ms-to-cycle conversion
package key_pkg;

    localparam int unsigned KEY_LOCKOUT_MS = 500;
    localparam int unsigned KEY_LONG_MS    = 2000;

    typedef enum logic [2:0] {
        IDLE,
        B_IN,
        HOLD,
        B_OUT,
        GAP
    } key_gen_state_t;

    function automatic int unsigned ms_to_cyc(input int unsigned ms, input int unsigned clk_hz);
        return ms * (clk_hz / 1000);
    endfunction

endpackage

// File: rtl/key_timer.sv
// rtl/key_timer.sv - loadable down-counter that flags its last counted cycle
module key_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_expire
);

    logic [W-1:0] r_count;

    // Holds at zero once drained so an idle timer never re-expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_expire = (r_count == W'(1));

endmodule

// File: rtl/key_press_gen.sv
// rtl/key_press_gen.sv - push-button waveform generator with contact bounce for key-path self-test
module key_press_gen
    import key_pkg::*;
#(
    parameter int unsigned IN_C_HZ    = 50_000_000,
    parameter int unsigned SHORT_MS   = 200,
    parameter int unsigned LONG_MS    = 2500,
    parameter int unsigned GAP_MS     = 600,
    parameter int unsigned BOUNCE_N   = 3,
    parameter int unsigned BOUNCE_CYC = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd_valid,
    input  logic cmd_long,
    output logic cmd_ready,
    output logic key_out,
    output logic busy,
    output logic done
);

    if (SHORT_MS >= KEY_LONG_MS) begin : g_bad_short
        $error("SHORT_MS must be below the debouncer long-press threshold");
    end
    if (LONG_MS <= KEY_LONG_MS) begin : g_bad_long
        $error("LONG_MS must exceed the debouncer long-press threshold");
    end
    if (GAP_MS <= KEY_LOCKOUT_MS) begin : g_bad_gap
        $error("GAP_MS must exceed the debouncer post-release lockout");
    end
    if (BOUNCE_CYC < 1) begin : g_bad_bounce
        $error("BOUNCE_CYC must be at least 1");
    end

    localparam int unsigned SHORT_CYC = ms_to_cyc(SHORT_MS, IN_C_HZ);
    localparam int unsigned LONG_CYC  = ms_to_cyc(LONG_MS, IN_C_HZ);
    localparam int unsigned GAP_CYC   = ms_to_cyc(GAP_MS, IN_C_HZ);
    localparam int unsigned MAX_A     = (SHORT_CYC > LONG_CYC) ? SHORT_CYC : LONG_CYC;
    localparam int unsigned MAX_B     = (GAP_CYC > BOUNCE_CYC) ? GAP_CYC : BOUNCE_CYC;
    localparam int unsigned MAX_CYC   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int          TW        = $clog2(MAX_CYC) + 1;
    localparam int          GW        = $clog2(BOUNCE_N + 2);

    localparam logic [TW-1:0] T_SHORT  = TW'(SHORT_CYC);
    localparam logic [TW-1:0] T_LONG   = TW'(LONG_CYC);
    localparam logic [TW-1:0] T_GAP    = TW'(GAP_CYC);
    localparam logic [TW-1:0] T_BOUNCE = TW'(BOUNCE_CYC);
    localparam logic [GW-1:0] G_INIT   = GW'(BOUNCE_N);
    localparam bit            HAS_BOUNCE = (BOUNCE_N > 0);

    key_gen_state_t r_state, w_state_next;
    logic           r_key_out, w_key_next;
    logic           r_done, w_done_next;
    logic           r_long, w_long_next;
    logic           r_phase, w_phase_next;
    logic [GW-1:0]  r_glitch, w_glitch_next;
    logic           w_load;
    logic [TW-1:0]  w_load_val;
    logic           w_expire;

    key_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_value  (w_load_val),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_key_out <= 1'b0;
            r_done    <= 1'b0;
            r_long    <= 1'b0;
            r_phase   <= 1'b0;
            r_glitch  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_key_out <= w_key_next;
            r_done    <= w_done_next;
            r_long    <= w_long_next;
            r_phase   <= w_phase_next;
            r_glitch  <= w_glitch_next;
        end
    end

    // key_out is computed alongside the transition so it changes on the same edge as the state.
    always_comb begin
        w_state_next  = r_state;
        w_key_next    = r_key_out;
        w_done_next   = 1'b0;
        w_long_next   = r_long;
        w_phase_next  = r_phase;
        w_glitch_next = r_glitch;
        w_load        = 1'b0;
        w_load_val    = '0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_long_next = cmd_long;
                    w_key_next  = 1'b1;
                    w_load      = 1'b1;
                    if (HAS_BOUNCE) begin
                        w_state_next  = B_IN;
                        w_load_val    = T_BOUNCE;
                        w_glitch_next = G_INIT;
                        w_phase_next  = 1'b0;
                    end else begin
                        w_state_next = HOLD;
                        w_load_val   = cmd_long ? T_LONG : T_SHORT;
                    end
                end
            end
            B_IN: begin
                if (w_expire) begin
                    w_load = 1'b1;
                    if (!r_phase) begin
                        w_phase_next = 1'b1;
                        w_key_next   = 1'b0;
                        w_load_val   = T_BOUNCE;
                    end else if (r_glitch == GW'(1)) begin
                        w_state_next = HOLD;
                        w_key_next   = 1'b1;
                        w_load_val   = r_long ? T_LONG : T_SHORT;
                    end else begin
                        w_glitch_next = r_glitch - GW'(1);
                        w_phase_next  = 1'b0;
                        w_key_next    = 1'b1;
                        w_load_val    = T_BOUNCE;
                    end
                end
            end
            HOLD: begin
                if (w_expire) begin
                    w_load     = 1'b1;
                    w_key_next = 1'b0;
                    if (HAS_BOUNCE) begin
                        w_state_next  = B_OUT;
                        w_load_val    = T_BOUNCE;
                        w_glitch_next = G_INIT;
                        w_phase_next  = 1'b0;
                    end else begin
                        w_state_next = GAP;
                        w_load_val   = T_GAP;
                    end
                end
            end
            B_OUT: begin
                if (w_expire) begin
                    w_load = 1'b1;
                    if (!r_phase) begin
                        w_phase_next = 1'b1;
                        w_key_next   = 1'b1;
                        w_load_val   = T_BOUNCE;
                    end else if (r_glitch == GW'(1)) begin
                        w_state_next = GAP;
                        w_key_next   = 1'b0;
                        w_load_val   = T_GAP;
                    end else begin
                        w_glitch_next = r_glitch - GW'(1);
                        w_phase_next  = 1'b0;
                        w_key_next    = 1'b0;
                        w_load_val    = T_BOUNCE;
                    end
                end
            end
            GAP: begin
                if (w_expire) begin
                    w_state_next = IDLE;
                    w_key_next   = 1'b0;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_key_next   = 1'b0;
            end
        endcase
    end

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign key_out   = r_key_out;
    assign done      = r_done;

endmodule

// File: tb/tb_key_press_gen.sv
// tb/tb_key_press_gen.sv - self-checking bench for key_press_gen with waveform and press-classifier models
module tb_key_press_gen;
    import key_pkg::*;

    localparam int HZ  = 1000;
    localparam int S   = 200;
    localparam int L   = 2500;
    localparam int G   = 600;
    localparam int BN  = 3;
    localparam int BC  = 2;
    localparam int DEB = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_long = 1'b0;
    logic cmd_ready, key_out, busy, done;
    logic cmd_valid0 = 1'b0, cmd_long0 = 1'b0;
    logic cmd_ready0, key_out0, busy0, done0;

    always #5 clk = ~clk;

    key_press_gen #(
        .IN_C_HZ(HZ), .SHORT_MS(S), .LONG_MS(L), .GAP_MS(G), .BOUNCE_N(BN), .BOUNCE_CYC(BC)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_long(cmd_long),
        .cmd_ready(cmd_ready), .key_out(key_out), .busy(busy), .done(done)
    );

    key_press_gen #(
        .IN_C_HZ(HZ), .SHORT_MS(S), .LONG_MS(L), .GAP_MS(G), .BOUNCE_N(0), .BOUNCE_CYC(BC)
    ) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_long(cmd_long0),
        .cmd_ready(cmd_ready0), .key_out(key_out0), .busy(busy0), .done(done0)
    );

    bit   use0 = 1'b0;
    logic key_s, rdy_s, busy_s, done_s;
    assign key_s  = use0 ? key_out0   : key_out;
    assign rdy_s  = use0 ? cmd_ready0 : cmd_ready;
    assign busy_s = use0 ? busy0      : busy;
    assign done_s = use0 ? done0      : done;

    int n_checks = 0;
    int n_fail   = 0;
    bit klog[$];
    bit expq[$];
    int cls_q[$];

    // Expected key line for one press, starting the cycle after accept.
    function automatic void build_exp(input bit lng, input int bn);
        expq.delete();
        for (int g = 0; g < bn; g++) begin
            for (int c = 0; c < BC; c++) expq.push_back(1'b1);
            for (int c = 0; c < BC; c++) expq.push_back(1'b0);
        end
        for (int c = 0; c < (lng ? L : S); c++) expq.push_back(1'b1);
        for (int g = 0; g < bn; g++) begin
            for (int c = 0; c < BC; c++) expq.push_back(1'b0);
            for (int c = 0; c < BC; c++) expq.push_back(1'b1);
        end
        for (int c = 0; c < G; c++) expq.push_back(1'b0);
    endfunction

    // Debouncer model: stable-high runs of DEB+ ms are presses, honouring the release lockout.
    function automatic void classify();
        int run;
        int last_rel;
        cls_q.delete();
        run = 0;
        last_rel = -100000;
        for (int i = 0; i <= klog.size(); i++) begin
            if (i < klog.size() && klog[i]) begin
                run++;
            end else begin
                if (run >= DEB && (i - run - last_rel) >= int'(KEY_LOCKOUT_MS)) begin
                    cls_q.push_back((run >= int'(KEY_LONG_MS)) ? 1 : 0);
                    last_rel = i;
                end
                run = 0;
            end
        end
    endfunction

    task automatic set_valid(input bit u0, input bit v);
        if (u0) cmd_valid0 = v;
        else    cmd_valid  = v;
    endtask

    task automatic do_press(input bit u0, input bit lng, input bit hold_valid,
                            input int rej_start, input int rej_len);
        int n, bad, first_bad, busy_bad, done_bad;
        use0 = u0;
        build_exp(lng, u0 ? 0 : BN);
        if (u0) cmd_long0 = lng;
        else    cmd_long  = lng;
        set_valid(u0, 1'b1);
        n = 0;
        while (rdy_s !== 1'b1 && n < 12000) begin
            @(negedge clk);
            klog.push_back(key_s);
            n++;
        end
        n_checks++;
        if (n >= 12000) begin
            $display("FAIL accept_wait: cmd_ready=%b after %0d cycles, required 1", rdy_s, n);
            n_fail++;
            set_valid(u0, 1'b0);
            return;
        end
        @(negedge clk);
        if (!hold_valid) set_valid(u0, 1'b0);
        n_checks++;
        if (rdy_s !== 1'b0) begin
            $display("FAIL ready_drop: cmd_ready=%b after accept, required 0", rdy_s);
            n_fail++;
        end
        bad = 0; first_bad = -1; busy_bad = 0; done_bad = 0;
        for (int k = 0; k < expq.size(); k++) begin
            if (k > 0) @(negedge clk);
            if (rej_len > 0 && k == rej_start) set_valid(u0, 1'b1);
            if (rej_len > 0 && k == rej_start + rej_len) set_valid(u0, 1'b0);
            klog.push_back(key_s);
            if (key_s !== logic'(expq[k])) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
            if (busy_s !== 1'b1) busy_bad++;
            if (done_s !== 1'b0) done_bad++;
        end
        n_checks++;
        if (bad != 0) begin
            $display("FAIL waveform: %0d wrong cycles, first at cycle %0d after accept, required 0 wrong (long=%0b u0=%0b)",
                     bad, first_bad + 1, lng, u0);
            n_fail++;
        end
        n_checks++;
        if (busy_bad != 0) begin
            $display("FAIL busy_high: busy low on %0d press cycles, required 0", busy_bad);
            n_fail++;
        end
        n_checks++;
        if (done_bad != 0) begin
            $display("FAIL done_early: done high on %0d press cycles, required 0", done_bad);
            n_fail++;
        end
        @(negedge clk);
        klog.push_back(key_s);
        n_checks++;
        if ({done_s, rdy_s, busy_s, key_s} !== 4'b1100) begin
            $display("FAIL end_of_press: done,ready,busy,key=%b%b%b%b, required 1100",
                     done_s, rdy_s, busy_s, key_s);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({key_out, cmd_ready, busy, done} !== 4'b0100) begin
            $display("FAIL reset_main: key,ready,busy,done=%b%b%b%b, required 0100",
                     key_out, cmd_ready, busy, done);
            n_fail++;
        end
        n_checks++;
        if ({key_out0, cmd_ready0, busy0, done0} !== 4'b0100) begin
            $display("FAIL reset_nobounce: key,ready,busy,done=%b%b%b%b, required 0100",
                     key_out0, cmd_ready0, busy0, done0);
            n_fail++;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({key_out, cmd_ready, busy, done} !== 4'b0100) begin
            $display("FAIL post_reset_idle: key,ready,busy,done=%b%b%b%b, required 0100",
                     key_out, cmd_ready, busy, done);
            n_fail++;
        end
    endtask

    task automatic check_classes(input string name, input int exp_cls[$]);
        classify();
        n_checks++;
        if (cls_q != exp_cls) begin
            $display("FAIL %s: classifier saw %0d presses %p, required %p", name, cls_q.size(), cls_q, exp_cls);
            n_fail++;
        end
    endtask

    task automatic test_short();
        klog.delete();
        do_press(1'b0, 1'b0, 1'b0, 0, 0);
        check_classes("short_class", '{0});
    endtask

    task automatic test_long();
        klog.delete();
        repeat ($urandom_range(0, 7)) @(negedge clk);
        do_press(1'b0, 1'b1, 1'b0, 0, 0);
        check_classes("long_class", '{1});
    endtask

    task automatic test_back_to_back();
        int seq[$];
        seq = '{0, 1, 0};
        if ($urandom_range(0, 1) == 1) seq[2] = int'($urandom_range(0, 1));
        klog.delete();
        for (int i = 0; i < 3; i++) do_press(1'b0, seq[i][0], i < 2, 0, 0);
        check_classes("b2b_class", seq);
    endtask

    task automatic test_no_bounce();
        klog.delete();
        do_press(1'b1, 1'b0, 1'b0, 0, 0);
        check_classes("nobounce_class", '{0});
        use0 = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        int hc, bad;
        hc = int'($urandom_range(1, 150));
        use0 = 1'b0;
        cmd_long = 1'($urandom_range(0, 1));
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (12 + hc) @(negedge clk);
        n_checks++;
        if (key_out !== 1'b1) begin
            $display("FAIL hold_before_rst: key_out=%b at hold cycle %0d, required 1", key_out, hc);
            n_fail++;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({key_out, cmd_ready, busy, done} !== 4'b0100) begin
            $display("FAIL async_rst: key,ready,busy,done=%b%b%b%b, required 0100",
                     key_out, cmd_ready, busy, done);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 900; k++) begin
            @(negedge clk);
            if ({key_out, cmd_ready, busy, done} !== 4'b0100) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            $display("FAIL post_rst_quiet: %0d cycles not idle after reset, required 0", bad);
            n_fail++;
        end
    endtask

    task automatic test_busy_reject();
        int rs, rl, bad;
        bit lng;
        lng = 1'($urandom_range(0, 1));
        rs = 12 + int'($urandom_range(5, 150));
        rl = int'($urandom_range(1, 50));
        klog.delete();
        do_press(1'b0, lng, 1'b0, rs, rl);
        bad = 0;
        for (int k = 0; k < 900; k++) begin
            @(negedge clk);
            klog.push_back(key_out);
            if (key_out !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            $display("FAIL reject_quiet: %0d active cycles after press, required 0", bad);
            n_fail++;
        end
        check_classes("reject_class", '{int'(lng)});
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_back_to_back();
        test_no_bounce();
        test_reset_mid_hold();
        test_busy_reject();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
